dlx_multicycle_sequencer: RTL and testbench
===========================================

Name: dlx_multicycle_sequencer

Overview:
- Moore-style multicycle control FSM for the DLX integer datapath.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, drives instruction/data memory handshakes, and issues PC/IR/register-file write strobes and mux selects.
- ALU function selection stays with the instruction decoder; this block only classifies the opcode to choose a path.
- Also counts retired instructions and flags illegal opcodes and bus timeouts.

Parameters:
- CNT_W, 32, width of the retired-instruction counter
- TIMEOUT, 16, maximum cycles to wait for a memory ack; 0 disables the timeout

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- run  in  1  1 = execute; sampled in IDLE and at each instruction end
- ir  in  32  registered instruction (IR output)
- zero  in  1  register-operand-equals-zero flag, valid in EXEC
- imem_ack  in  1  instruction memory data valid
- dmem_ack  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load; valid only with dmem_req
- ir_we  out  1  IR load strobe
- pc_we  out  1  PC load strobe
- pc_sel  out  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = register
- rf_we  out  1  register-file write strobe
- rf_dst_sel  out  2  0 = rd ir[15:11], 1 = rt ir[20:16], 2 = r31
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = link (PC)
- alu_src_imm  out  1  1 = ALU B operand is the immediate
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- bus_err  out  1  one-cycle pulse on a memory timeout
- state  out  3  IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5
- instr_count  out  CNT_W  retired-instruction count; wraps modulo 2^CNT_W

Behaviour:
- Reset: rst_n = 0 at a clock edge forces state = IDLE, instr_count = 0, timeout counter = 0. Applies mid-instruction and mid-handshake. All outputs are 0 while in IDLE.
- IDLE: run = 1 -> FETCH; otherwise stay in IDLE.
- FETCH:
  - imem_req = 1, held until ack.
  - On imem_ack: ir_we = 1, pc_we = 1, pc_sel = 0 in the same cycle, then go to DECODE.
- DECODE (one cycle), opcode = ir[31:26]:
  - R-type: 0x00.
  - ALU-imm: 0x08-0x0F, 0x14, 0x16-0x1D.
  - Load: 0x20, 0x21, 0x23, 0x24, 0x25.
  - Store: 0x28, 0x29, 0x2B.
  - Branch: 0x04 BEQZ, 0x05 BNEZ.
  - Jump: 0x02 J, 0x03 JAL, 0x12 JR, 0x13 JALR.
  - NOP: 0x15.
  - Any other opcode: illegal_op = 1, then take the END transition.
  - All legal opcodes go to EXEC.
- EXEC:
  - alu_src_imm = 1 for ALU-imm, load and store.
  - Branch: pc_we = (BEQZ & zero) | (BNEZ & ~zero), pc_sel = 1, then END.
  - J: pc_we = 1, pc_sel = 2, then END.
  - JR: pc_we = 1, pc_sel = 3, then END.
  - JAL / JALR: go to WB.
  - Load / store: go to MEM.
  - R-type / ALU-imm: go to WB.
  - NOP: END.
- MEM:
  - dmem_req = 1, dmem_we = 1 for store, alu_src_imm held at 1.
  - On dmem_ack: load goes to WB; store takes END.
- WB (one cycle):
  - R-type: rf_we = 1, rf_dst_sel = 0, wb_sel = 0.
  - ALU-imm: rf_we = 1, rf_dst_sel = 1, wb_sel = 0.
  - Load: rf_we = 1, rf_dst_sel = 1, wb_sel = 1.
  - JAL: rf_we = 1, rf_dst_sel = 2, wb_sel = 2, plus pc_we = 1 with pc_sel = 2 in the same cycle. The RF captures the old PC (PC+4).
  - JALR: same as JAL but pc_sel = 3.
  - Then END.
- END transition:
  - instr_count += 1 on that edge, except after an illegal opcode or a timeout.
  - Next state is FETCH if run = 1, else IDLE.
  - run = 0 never aborts an instruction already in flight.
- Timeout:
  - The counter clears on entry to FETCH/MEM and increments each waiting cycle.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT without an ack: bus_err = 1, request dropped, state -> IDLE.
  - An ack arriving in the same cycle the counter reaches TIMEOUT wins: normal transition, no bus_err.
- Ack outside FETCH/MEM is ignored.
- Any state encoding outside 0-5 -> IDLE on the next edge.

Test Plan:
- Reset, run = 1, ADD ir = 0x00221820, imem_ack after 2 wait cycles -> state sequence 0,1,1,1,2,3,5,1; rf_we with rf_dst_sel = 0 in WB; instr_count = 1.
- LW ir = 0x8C220004, dmem_ack after 3 cycles -> dmem_req high 4 cycles with dmem_we = 0; WB wb_sel = 1, rf_dst_sel = 1.
- BEQZ ir = 0x10200010: run once with zero = 1 and once with zero = 0 -> pc_we = 1/pc_sel = 1 in EXEC for zero = 1; pc_we = 0 for zero = 0; both return to FETCH.
- JAL ir = 0x0C000040 -> WB asserts rf_we, rf_dst_sel = 2, wb_sel = 2, pc_we, pc_sel = 2 in one cycle.
- Opcode 0x3F -> illegal_op pulses in DECODE; instr_count unchanged; next state FETCH.
- TIMEOUT = 16, imem_ack never asserted -> bus_err after 16 FETCH cycles, state = IDLE; rst_n = 0 asserted during MEM -> IDLE with all outputs 0 on the next edge.

Source files
------------

// File: rtl/dlx_multicycle_sequencer.sv
// Multicycle control sequencer for the DLX integer datapath.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB, runs the
// instruction/data memory handshakes, and issues PC/IR/register-file
// strobes and mux selects. It also counts retired instructions and flags
// illegal opcodes and memory timeouts.
//
// Handshake: a request (imem_req / dmem_req) is raised on entry to FETCH / MEM
// and held every cycle until the matching ack is seen high in a cycle where the
// request is high. That cycle completes the transfer. Acks seen while no
// request is outstanding are ignored. A request that waits TIMEOUT cycles
// without an ack is dropped and reported on bus_err.
module dlx_multicycle_sequencer #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [31:0]      ir,
    input  logic             zero,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             rf_we,
    output logic [1:0]       rf_dst_sel,
    output logic [1:0]       wb_sel,
    output logic             alu_src_imm,
    output logic             illegal_op,
    output logic             bus_err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_RTYPE, C_ALUI, C_LOAD, C_STORE, C_BEQZ, C_BNEZ,
        C_J, C_JAL, C_JR, C_JALR, C_NOP, C_ILL
    } cls_t;

    localparam int TO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    state_t          cur_state;
    state_t          next_state;
    cls_t            dec_cls;
    cls_t            cls_q;
    logic [TO_W-1:0] wait_cnt;
    logic            timeout_hit;
    logic            waiting;
    logic            retire;
    logic            finish;
    logic            unused_ir_bits;

    // Only the opcode field matters here; the ALU function is decoded elsewhere.
    assign unused_ir_bits = ^ir[25:0];

    function automatic cls_t classify(input logic [5:0] op);
        cls_t c;
        case (op) inside
            6'h00:                             c = C_RTYPE;
            [6'h08:6'h0F], 6'h14, [6'h16:6'h1D]: c = C_ALUI;
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: c = C_LOAD;
            6'h28, 6'h29, 6'h2B:               c = C_STORE;
            6'h04:                             c = C_BEQZ;
            6'h05:                             c = C_BNEZ;
            6'h02:                             c = C_J;
            6'h03:                             c = C_JAL;
            6'h12:                             c = C_JR;
            6'h13:                             c = C_JALR;
            6'h15:                             c = C_NOP;
            default:                           c = C_ILL;
        endcase
        return c;
    endfunction

    assign dec_cls     = classify(ir[31:26]);
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == TO_W'(TO_LAST));
    assign state       = cur_state;

    // Next-state and control strobes, decoded from the current state, the latched opcode class and the acks.
    always_comb begin
        next_state  = cur_state;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = 2'd0;
        rf_we       = 1'b0;
        rf_dst_sel  = 2'd0;
        wb_sel      = 2'd0;
        alu_src_imm = 1'b0;
        illegal_op  = 1'b0;
        bus_err     = 1'b0;
        waiting     = 1'b0;
        retire      = 1'b0;
        finish      = 1'b0;
        case (cur_state)
            S_IDLE: begin
                if (run) next_state = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we      = 1'b1;
                    pc_we      = 1'b1;
                    next_state = S_DECODE;
                end else if (timeout_hit) begin
                    bus_err    = 1'b1;
                    next_state = S_IDLE;
                end else begin
                    waiting = 1'b1;
                end
            end
            S_DECODE: begin
                if (dec_cls == C_ILL) begin
                    illegal_op = 1'b1;
                    finish     = 1'b1;
                end else begin
                    next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_src_imm = (cls_q == C_ALUI) || (cls_q == C_LOAD) || (cls_q == C_STORE);
                case (cls_q)
                    C_BEQZ:  begin pc_we = zero;  pc_sel = 2'd1; retire = 1'b1; end
                    C_BNEZ:  begin pc_we = ~zero; pc_sel = 2'd1; retire = 1'b1; end
                    C_J:     begin pc_we = 1'b1;  pc_sel = 2'd2; retire = 1'b1; end
                    C_JR:    begin pc_we = 1'b1;  pc_sel = 2'd3; retire = 1'b1; end
                    C_NOP:   retire = 1'b1;
                    C_LOAD, C_STORE: next_state = S_MEM;
                    C_RTYPE, C_ALUI, C_JAL, C_JALR: next_state = S_WB;
                    default: next_state = S_IDLE;
                endcase
            end
            S_MEM: begin
                dmem_req    = 1'b1;
                dmem_we     = (cls_q == C_STORE);
                alu_src_imm = 1'b1;
                if (dmem_ack) begin
                    if (cls_q == C_STORE) retire = 1'b1;
                    else                  next_state = S_WB;
                end else if (timeout_hit) begin
                    bus_err    = 1'b1;
                    next_state = S_IDLE;
                end else begin
                    waiting = 1'b1;
                end
            end
            S_WB: begin
                rf_we  = 1'b1;
                retire = 1'b1;
                case (cls_q)
                    C_ALUI: rf_dst_sel = 2'd1;
                    C_LOAD: begin rf_dst_sel = 2'd1; wb_sel = 2'd1; end
                    C_JAL:  begin rf_dst_sel = 2'd2; wb_sel = 2'd2; pc_we = 1'b1; pc_sel = 2'd2; end
                    C_JALR: begin rf_dst_sel = 2'd2; wb_sel = 2'd2; pc_we = 1'b1; pc_sel = 2'd3; end
                    default: rf_dst_sel = 2'd0;
                endcase
            end
            default: next_state = S_IDLE;
        endcase
        if (retire) finish = 1'b1;
        // The end of an instruction is the only point where run is re-examined.
        if (finish) next_state = run ? S_FETCH : S_IDLE;
    end

    // State, latched opcode class, handshake wait counter and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state   <= S_IDLE;
            cls_q       <= C_NOP;
            wait_cnt    <= '0;
            instr_count <= '0;
        end else begin
            cur_state <= next_state;
            if (cur_state == S_DECODE) cls_q <= dec_cls;
            if (waiting) wait_cnt <= wait_cnt + TO_W'(1);
            else         wait_cnt <= '0;
            if (retire) instr_count <= instr_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dlx_multicycle_sequencer.sv
// Directed bench for dlx_multicycle_sequencer. A transaction-level model
// expands each instruction into its expected per-cycle output vectors, and
// one compare process checks every cycle against that queue.
module tb_dlx_multicycle_sequencer;

    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 16;
    localparam int OW      = 18;
    localparam int EW      = OW + CNT_W;

    localparam int K_R = 0, K_ALUI = 1, K_LOAD = 2, K_STORE = 3, K_BEQZ = 4, K_BNEZ = 5;
    localparam int K_J = 6, K_JAL = 7, K_JR = 8, K_JALR = 9, K_NOP = 10, K_ILL = 11;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       rf_we;
        logic [1:0] dst;
        logic [1:0] wbs;
        logic       imm;
        logic       ill;
        logic       berr;
    } outs_t;

    logic             clk;
    logic             rst_n;
    logic             run;
    logic [31:0]      ir;
    logic             zero;
    logic             imem_ack;
    logic             dmem_ack;
    logic             imem_req;
    logic             dmem_req;
    logic             dmem_we;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       pc_sel;
    logic             rf_we;
    logic [1:0]       rf_dst_sel;
    logic [1:0]       wb_sel;
    logic             alu_src_imm;
    logic             illegal_op;
    logic             bus_err;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_count;

    logic [EW-1:0]    exp_q[$];
    logic [CNT_W-1:0] exp_cnt;
    int               cls_tab[64];
    int               state_log[$];
    int               req_log[$];
    int               total;
    int               bad;

    dlx_multicycle_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .ir(ir), .zero(zero),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
        .rf_dst_sel(rf_dst_sel), .wb_sel(wb_sel), .alu_src_imm(alu_src_imm),
        .illegal_op(illegal_op), .bus_err(bus_err), .state(state),
        .instr_count(instr_count)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare process: one expected vector per driven cycle, checked mid-cycle.
    always @(negedge clk) begin : compare
        outs_t         g;
        logic [EW-1:0] a;
        logic [EW-1:0] e;
        g          = '0;
        g.st       = state;
        g.imem_req = imem_req;
        g.dmem_req = dmem_req;
        g.dmem_we  = dmem_we;
        g.ir_we    = ir_we;
        g.pc_we    = pc_we;
        g.pc_sel   = pc_sel;
        g.rf_we    = rf_we;
        g.dst      = rf_dst_sel;
        g.wbs      = wb_sel;
        g.imm      = alu_src_imm;
        g.ill      = illegal_op;
        g.berr     = bus_err;
        a = {g, instr_count};
        state_log.push_back(int'(state));
        req_log.push_back(int'(dmem_req));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL cycle_outputs t=%0t got=%h want=%h", $time, a, e);
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    function automatic outs_t blank(input int st);
        outs_t o;
        o    = '0;
        o.st = 3'(st);
        return o;
    endfunction

    // Queue the expectation for the current cycle, then advance one clock.
    task automatic cyc(input outs_t e);
        exp_q.push_back({e, exp_cnt});
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_phase(input int iw, input logic [31:0] ir_v);
        outs_t o;
        imem_ack = 1'b0;
        o = blank(1);
        o.imem_req = 1'b1;
        repeat (iw) cyc(o);
        imem_ack = 1'b1;
        o.ir_we = 1'b1;
        o.pc_we = 1'b1;
        cyc(o);
        imem_ack = 1'b0;
        ir = ir_v;
    endtask

    // One full instruction from FETCH onward; the model is the opcode's class.
    task automatic do_instr(input logic [31:0] ir_v, input int iw, input int dw,
                            input logic z, input logic run_v);
        int    k;
        outs_t o;
        logic  ends_exec;
        k = cls_tab[ir_v[31:26]];
        fetch_phase(iw, ir_v);
        run  = run_v;
        zero = z;
        o = blank(2);
        if (k == K_ILL) begin
            o.ill = 1'b1;
            cyc(o);
        end else begin
            cyc(o);
            o = blank(3);
            o.imm = (k == K_ALUI) || (k == K_LOAD) || (k == K_STORE);
            if (k == K_BEQZ) begin o.pc_we = z;    o.pc_sel = 2'd1; end
            if (k == K_BNEZ) begin o.pc_we = !z;   o.pc_sel = 2'd1; end
            if (k == K_J)    begin o.pc_we = 1'b1; o.pc_sel = 2'd2; end
            if (k == K_JR)   begin o.pc_we = 1'b1; o.pc_sel = 2'd3; end
            ends_exec = (k == K_BEQZ) || (k == K_BNEZ) || (k == K_J) || (k == K_JR) || (k == K_NOP);
            cyc(o);
            if (ends_exec) begin
                exp_cnt = exp_cnt + 1;
            end else begin
                if (k == K_LOAD || k == K_STORE) begin
                    o = blank(4);
                    o.dmem_req = 1'b1;
                    o.dmem_we  = (k == K_STORE);
                    o.imm      = 1'b1;
                    dmem_ack = 1'b0;
                    repeat (dw) cyc(o);
                    dmem_ack = 1'b1;
                    cyc(o);
                    dmem_ack = 1'b0;
                end
                if (k != K_STORE) begin
                    o = blank(5);
                    o.rf_we = 1'b1;
                    if (k == K_ALUI || k == K_LOAD) o.dst = 2'd1;
                    if (k == K_LOAD) o.wbs = 2'd1;
                    if (k == K_JAL || k == K_JALR) begin
                        o.dst    = 2'd2;
                        o.wbs    = 2'd2;
                        o.pc_we  = 1'b1;
                        o.pc_sel = (k == K_JAL) ? 2'd2 : 2'd3;
                    end
                    cyc(o);
                end
                exp_cnt = exp_cnt + 1;
            end
        end
    endtask

    // Watchdog so a stuck run still terminates with a visible failure.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    // Directed scenario sequence.
    initial begin
        outs_t o;
        int    add_seq[7];
        int    n;
        add_seq = '{0, 1, 1, 1, 2, 3, 5};
        total = 0; bad = 0; exp_cnt = '0;
        rst_n = 1'b0; run = 1'b0; ir = '0; zero = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        for (int i = 0; i < 64; i++) cls_tab[i] = K_ILL;
        cls_tab[6'h00] = K_R;
        for (int i = 8'h08; i <= 8'h0F; i++) cls_tab[i] = K_ALUI;
        cls_tab[6'h14] = K_ALUI;
        for (int i = 8'h16; i <= 8'h1D; i++) cls_tab[i] = K_ALUI;
        cls_tab[6'h20] = K_LOAD; cls_tab[6'h21] = K_LOAD; cls_tab[6'h23] = K_LOAD;
        cls_tab[6'h24] = K_LOAD; cls_tab[6'h25] = K_LOAD;
        cls_tab[6'h28] = K_STORE; cls_tab[6'h29] = K_STORE; cls_tab[6'h2B] = K_STORE;
        cls_tab[6'h04] = K_BEQZ; cls_tab[6'h05] = K_BNEZ;
        cls_tab[6'h02] = K_J; cls_tab[6'h03] = K_JAL; cls_tab[6'h12] = K_JR; cls_tab[6'h13] = K_JALR;
        cls_tab[6'h15] = K_NOP;

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", int'(state), 0);
        check("reset_count", int'(instr_count), 0);
        rst_n = 1'b1;

        // Acks while idle are ignored.
        imem_ack = 1'b1; dmem_ack = 1'b1;
        cyc(blank(0));
        imem_ack = 1'b0; dmem_ack = 1'b0;
        cyc(blank(0));

        // ADD with two fetch wait cycles.
        state_log.delete();
        run = 1'b1;
        cyc(blank(0));
        do_instr(32'h00221820, 2, 0, 1'b0, 1'b1);
        check("add_log_len", state_log.size(), 7);
        for (int i = 0; i < 7; i++)
            check("add_state_seq", (i < state_log.size()) ? state_log[i] : -1, add_seq[i]);
        check("add_next_state", int'(state), 1);
        check("add_count", int'(instr_count), 1);

        // LW with three data wait cycles.
        req_log.delete();
        do_instr(32'h8C220004, 0, 3, 1'b0, 1'b1);
        n = 0;
        foreach (req_log[i]) n += req_log[i];
        check("lw_dmem_req_cycles", n, 4);
        check("lw_count", int'(instr_count), 2);

        do_instr(32'h20220005, 1, 0, 1'b0, 1'b1);   // ADDI
        do_instr(32'hAC220004, 0, 2, 1'b0, 1'b1);   // SW
        do_instr(32'h10200010, 0, 0, 1'b1, 1'b1);   // BEQZ taken
        do_instr(32'h10200010, 0, 0, 1'b0, 1'b1);   // BEQZ not taken
        do_instr(32'h14200010, 0, 0, 1'b0, 1'b1);   // BNEZ taken
        do_instr(32'h0C000040, 0, 0, 1'b0, 1'b1);   // JAL
        do_instr(32'h08000010, 0, 0, 1'b0, 1'b1);   // J
        do_instr(32'h48200000, 0, 0, 1'b0, 1'b1);   // JR
        do_instr(32'h4C200000, 0, 0, 1'b0, 1'b1);   // JALR
        do_instr(32'h54000000, TIMEOUT - 1, 0, 1'b0, 1'b1);  // NOP, ack on the last allowed cycle
        check("boundary_ack_count", int'(instr_count), 12);

        // Illegal opcode: no retire, continues to FETCH.
        do_instr(32'hFC000000, 0, 0, 1'b0, 1'b1);
        check("ill_count", int'(instr_count), 12);
        check("ill_next_state", int'(state), 1);

        // ORI with run dropped mid-instruction: finishes, then idles.
        do_instr(32'h34220001, 0, 0, 1'b0, 1'b0);
        check("stop_state", int'(state), 0);
        check("stop_count", int'(instr_count), 13);

        // Fetch timeout.
        run = 1'b1;
        cyc(blank(0));
        run = 1'b0;
        for (int i = 1; i <= TIMEOUT; i++) begin
            o = blank(1);
            o.imem_req = 1'b1;
            o.berr = (i == TIMEOUT);
            cyc(o);
        end
        check("timeout_state", int'(state), 0);
        check("timeout_count", int'(instr_count), 13);
        cyc(blank(0));

        // Reset asserted while a load waits in MEM.
        run = 1'b1;
        cyc(blank(0));
        fetch_phase(0, 32'h8C220004);
        cyc(blank(2));
        o = blank(3); o.imm = 1'b1;
        cyc(o);
        o = blank(4); o.dmem_req = 1'b1; o.imm = 1'b1;
        cyc(o);
        rst_n = 1'b0;
        cyc(o);
        rst_n = 1'b1;
        run = 1'b0;
        exp_cnt = '0;
        check("mem_reset_state", int'(state), 0);
        check("mem_reset_count", int'(instr_count), 0);
        cyc(blank(0));

        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
